irq_exc_ctrl: RTL
=================

Name: irq_exc_ctrl

Overview:
- Parametrised interrupt/exception sequencer for the pipelined processor.
- Replaces the single combinational IRQ/illegal-op priority inside the instruction decoder.
- Collects NUM_SRC interrupt lines (per-source edge or level), holds pending and mask state, and arbitrates against decoder exceptions.
- Drives a held redirect request, with vector and source id, into the PC-select/writeback path. Tracks user/kernel mode until eret.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..16)
- ID_W, 2, width of irq_id; must equal ceil(log2(NUM_SRC)), minimum 1
- EDGE_MASK, 4'b0011, per-source trigger mode: bit=1 rising-edge, bit=0 level-high
- MASK_RST, 0, mask register value after reset
- IRQ_BASE, 32'h80000004, interrupt vector for source 0; source i vectors to IRQ_BASE + 8*i
- EXC_VEC, 32'h80000008, illegal-instruction vector

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset
- irq_src  in  NUM_SRC  raw interrupt lines, already synchronous to clk
- illegal_inst  in  1  decoder flags an unsupported opcode/funct in the current ID instruction
- eret  in  1  decoder flags a return-from-kernel instruction
- stall  in  1  pipeline cannot accept a redirect this cycle
- mask_we  in  1  write mask register
- mask_wdata  in  NUM_SRC  new mask, 1 = enabled
- pend_clr  in  NUM_SRC  write-1-to-clear strobes for edge pending bits, one cycle
- take_irq  out  1  interrupt redirect request, held until accepted
- take_exc  out  1  exception redirect request, held until accepted
- vector  out  32  target PC while take_irq or take_exc is high, else 0
- irq_id  out  ID_W  index of the source being taken
- pending  out  NUM_SRC  current pending bits
- mask  out  NUM_SRC  current mask
- in_kernel  out  1  1 while in REDIRECT or KERNEL
- double_fault  out  1  sticky; set by illegal_inst while in KERNEL

Behaviour:
- Reset (async, reset=0): state USER; take_irq, take_exc, in_kernel, double_fault = 0; vector = 0; irq_id = 0; pending = 0; edge-history register = 0; mask = MASK_RST.
- Edge sources:
  - pending[i] sets on a clk edge where irq_src[i]=1 and the previous-cycle sample was 0.
  - pending[i] clears on pend_clr[i]=1, or on acceptance of a redirect for source i.
  - If set and clear occur in the same cycle, set wins.
- Level sources: pending[i] is a registered copy of irq_src[i]. pend_clr and acceptance have no effect on it.
- Request in USER:
  - Exception request = illegal_inst.
  - Interrupt request = |(pending & mask).
  - Exception outranks interrupt. Among interrupts, the lowest enabled pending index wins.
- State USER:
  - On a clk edge with any request, go to REDIRECT.
  - In the same edge, register the kind (exc or irq), irq_id and vector.
  - Latency: request sampled at edge N, take_* high from edge N to acceptance.
- State REDIRECT:
  - Exactly one of take_exc/take_irq is high; vector and irq_id are stable.
  - Held while stall=1. Arbitration is frozen: later or higher-priority requests do not alter the latched request.
  - On an edge with stall=0: go to KERNEL, drop take_*, set vector=0, and clear pending[irq_id] if that source is edge-mode.
- State KERNEL:
  - Interrupts are not taken; pending bits keep accumulating.
  - illegal_inst sets double_fault and does not redirect.
  - eret=1 goes to USER at the next edge. A request present in that cycle is evaluated in USER one cycle later.
- eret in USER or REDIRECT: ignored.
- mask_we: new mask effective from the next cycle. Arbitration in the write cycle uses the old mask.
- Masked pending bits remain visible on the pending output.
- Reset mid-REDIRECT: take_* drops asynchronously and the latched request is discarded.

Test Plan:
- Reset, then mask_we with mask_wdata=4'b1111; pulse irq_src[2] for 1 cycle, stall=0 -> pending[2]=1; next edge take_irq=1, irq_id=2, vector=32'h80000014 for one cycle; then in_kernel=1, pending[2]=0.
- illegal_inst=1 and pending[1] (enabled) in the same cycle -> take_exc=1, vector=32'h80000008; irq stays pending; after eret, take_irq with irq_id=1 appears 2 cycles after eret.
- REDIRECT with stall=1 for 3 cycles while irq_src[0] rises -> take_irq held with irq_id unchanged for 4 cycles; source 0 taken only after the following eret.
- Level source 3 (EDGE_MASK bit 3=0) held high with mask bit 3=0 -> no take, pending[3]=1; pend_clr[3]=1 has no effect; mask_we enabling bit 3 -> take_irq, irq_id=3, two edges after the write.
- In KERNEL, illegal_inst=1 -> double_fault=1 sticky, no take_exc; eret -> USER; double_fault stays 1 until reset.
- Assert reset=0 asynchronously mid-REDIRECT -> take_irq=0, vector=0, in_kernel=0 immediately; pending=0 and mask=MASK_RST.

Source files
------------

// File: rtl/irq_exc_ctrl.sv
// irq_exc_ctrl: interrupt/exception sequencer for the pipelined core.
// Collects edge/level IRQs, arbitrates against decoder exceptions and
// drives a held redirect request until the pipeline accepts it.
//
// Ports:
//   clk, reset          : rising-edge clock, async active-low reset
//   irq_src             : raw interrupt lines (synchronous to clk)
//   illegal_inst, eret  : decoder flags for the ID-stage instruction
//   stall               : pipeline cannot accept a redirect this cycle
//   mask_we, mask_wdata : mask register write port (1 = enabled)
//   pend_clr            : write-1-to-clear strobes for edge pending bits
//   take_irq, take_exc  : held redirect requests
//   vector, irq_id      : redirect target PC and taken source index
//   pending, mask       : current pending and mask state
//   in_kernel           : high in REDIRECT or KERNEL
//   double_fault        : sticky, illegal_inst seen while in KERNEL
module irq_exc_ctrl #(
    parameter int                 NUM_SRC   = 4,
    parameter int                 ID_W      = 2,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(4'b0011),
    parameter logic [NUM_SRC-1:0] MASK_RST  = '0,
    parameter logic [31:0]        IRQ_BASE  = 32'h8000_0004,
    parameter logic [31:0]        EXC_VEC   = 32'h8000_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               illegal_inst,
    input  logic               eret,
    input  logic               stall,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic [NUM_SRC-1:0] pend_clr,
    output logic               take_irq,
    output logic               take_exc,
    output logic [31:0]        vector,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               in_kernel,
    output logic               double_fault
);

    typedef enum logic [1:0] {
        ST_USER     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_KERNEL   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [NUM_SRC-1:0] r_hist;
    logic [NUM_SRC-1:0] r_pend;
    logic [NUM_SRC-1:0] r_mask;
    logic               r_take_irq;
    logic               r_take_exc;
    logic [31:0]        r_vector;
    logic [ID_W-1:0]    r_id;
    logic               r_dfault;

    logic               w_take_irq_nxt;
    logic               w_take_exc_nxt;
    logic [31:0]        w_vec_nxt;
    logic [ID_W-1:0]    w_id_nxt;
    logic               w_dfault_nxt;
    logic               w_accept;

    logic [NUM_SRC-1:0] w_act;
    logic               w_win_any;
    logic [ID_W-1:0]    w_win_id;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_acc_clr;
    logic [NUM_SRC-1:0] w_edge_nxt;
    logic [NUM_SRC-1:0] w_pend_nxt;

    // Lowest enabled pending index wins; scan downward so the
    // last assignment is the lowest set bit.
    always_comb begin
        w_act     = r_pend & r_mask;
        w_win_any = |w_act;
        w_win_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_win_id = ID_W'(i);
            end
        end
    end

    // Accepting an interrupt redirect retires that source's edge pend.
    always_comb begin
        w_acc_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_acc_clr[i] = w_accept & r_take_irq & (r_id == ID_W'(i));
        end
    end

    // Edge pend: a new rise in the same cycle as a clear keeps the bit.
    // Level pend: plain registered copy of the line.
    always_comb begin
        w_rise     = irq_src & ~r_hist;
        w_edge_nxt = w_rise | (r_pend & ~(pend_clr | w_acc_clr));
        w_pend_nxt = (EDGE_MASK & w_edge_nxt) | (~EDGE_MASK & irq_src);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_take_irq_nxt = r_take_irq;
        w_take_exc_nxt = r_take_exc;
        w_vec_nxt      = r_vector;
        w_id_nxt       = r_id;
        w_dfault_nxt   = r_dfault;
        w_accept       = 1'b0;
        unique case (r_state)
            ST_USER: begin
                if (illegal_inst) begin
                    w_state_nxt    = ST_REDIRECT;
                    w_take_exc_nxt = 1'b1;
                    w_vec_nxt      = EXC_VEC;
                    w_id_nxt       = '0;
                end else if (w_win_any) begin
                    w_state_nxt    = ST_REDIRECT;
                    w_take_irq_nxt = 1'b1;
                    w_vec_nxt      = IRQ_BASE + (32'(w_win_id) << 3);
                    w_id_nxt       = w_win_id;
                end
            end
            ST_REDIRECT: begin
                // Request is frozen until the pipeline takes it.
                if (!stall) begin
                    w_state_nxt    = ST_KERNEL;
                    w_take_irq_nxt = 1'b0;
                    w_take_exc_nxt = 1'b0;
                    w_vec_nxt      = '0;
                    w_accept       = 1'b1;
                end
            end
            ST_KERNEL: begin
                if (illegal_inst) begin
                    w_dfault_nxt = 1'b1;
                end
                if (eret) begin
                    w_state_nxt = ST_USER;
                end
            end
            default: begin
                w_state_nxt    = ST_USER;
                w_take_irq_nxt = 1'b0;
                w_take_exc_nxt = 1'b0;
                w_vec_nxt      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_USER;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist     <= '0;
            r_pend     <= '0;
            r_mask     <= MASK_RST;
            r_take_irq <= 1'b0;
            r_take_exc <= 1'b0;
            r_vector   <= '0;
            r_id       <= '0;
            r_dfault   <= 1'b0;
        end else begin
            r_hist     <= irq_src;
            r_pend     <= w_pend_nxt;
            r_take_irq <= w_take_irq_nxt;
            r_take_exc <= w_take_exc_nxt;
            r_vector   <= w_vec_nxt;
            r_id       <= w_id_nxt;
            r_dfault   <= w_dfault_nxt;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign take_irq     = r_take_irq;
    assign take_exc     = r_take_exc;
    assign vector       = r_vector;
    assign irq_id       = r_id;
    assign pending      = r_pend;
    assign mask         = r_mask;
    assign in_kernel    = (r_state != ST_USER);
    assign double_fault = r_dfault;

endmodule
